// File: rtl/scurve_multi_channel_if.sv
// Readout handshake bundle for the s-curve scanner.
// Master presents one channel count per transfer.
interface scurve_multi_channel_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 16
);
  logic             Rd_Valid;
  logic             Rd_Ready;
  logic [CH_W-1:0]  Rd_Channel;
  logic [CNT_W-1:0] Rd_Data;

  modport master (
    output Rd_Valid, Rd_Channel, Rd_Data,
    input  Rd_Ready
  );

  modport slave (
    input  Rd_Valid, Rd_Channel, Rd_Data,
    output Rd_Ready
  );
endinterface

// File: rtl/scurve_multi_channel.sv
// Multi-channel s-curve scanner: counts injected pulses and
// per-channel trigger responses, then reads the counts out.
module scurve_multi_channel #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 16,
  parameter int DLY_W  = 4
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              Test_Start,
  input  logic              Mode,
  input  logic              CLK_EXT,
  input  logic [CH_NUM-1:0] Trigger,
  input  logic [CH_NUM-1:0] ChannelMask,
  input  logic [CNT_W-1:0]  CPT_MAX,
  input  logic [DLY_W-1:0]  TriggerDelay,
  output logic [CNT_W-1:0]  CPT_PULSE,
  output logic              Busy,
  output logic              CPT_DONE,
  scurve_multi_channel_if.master rd
);
  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int DEPTH = (2 ** DLY_W) - 1;
  localparam logic [CH_W-1:0] LAST = CH_W'(CH_NUM - 1);

  typedef enum logic [1:0] {
    IDLE, COUNT, READOUT, DONE
  } state_t;

  state_t state;

  logic [1:0]                    ext_s;
  logic [CH_NUM-1:0]             trg_s1, trg_s2;
  logic [DEPTH-1:0]              ext_line;
  logic [DEPTH-1:0][CH_NUM-1:0]  trg_line;
  logic                          ext_tap, ext_prev;
  logic [CH_NUM-1:0]             trg_tap, trg_prev;
  logic [DLY_W-1:0]              dsel;
  logic                          ext_rise, ext_fall;
  logic [CH_NUM-1:0]             evt, hit, armed, arm_nxt;
  logic                          counting, start;
  logic [CNT_W-1:0]              cnt [CH_NUM];
  logic [CH_W-1:0]               nxt_ch;

  // Synchronizers and delay lines; the strobe is delayed
  // with the triggers so windows stay aligned to them.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_s    <= '0;
      trg_s1   <= '1;
      trg_s2   <= '1;
      ext_line <= '0;
      trg_line <= '1;
      ext_prev <= 1'b0;
      trg_prev <= '1;
    end else begin
      ext_s       <= {ext_s[0], CLK_EXT};
      trg_s1      <= Trigger;
      trg_s2      <= trg_s1;
      ext_line[0] <= ext_s[1];
      trg_line[0] <= trg_s2;
      for (int i = 1; i < DEPTH; i++) begin
        ext_line[i] <= ext_line[i-1];
        trg_line[i] <= trg_line[i-1];
      end
      ext_prev <= ext_tap;
      trg_prev <= trg_tap;
    end
  end

  // Delay tap select, edge flags and per-channel count enables.
  always_comb begin
    dsel    = TriggerDelay - DLY_W'(1);
    ext_tap = ext_s[1];
    trg_tap = trg_s2;
    if (TriggerDelay != '0) begin
      ext_tap = ext_line[dsel];
      trg_tap = trg_line[dsel];
    end
    ext_rise = ext_tap & ~ext_prev;
    ext_fall = ~ext_tap & ext_prev;
    evt      = trg_prev & ~trg_tap;
    counting = (state == COUNT);
    start    = (state == IDLE) & Test_Start;
    hit      = {CH_NUM{counting}} & ChannelMask & evt
             & (Mode ? armed : {CH_NUM{1'b1}});
    arm_nxt  = (armed | {CH_NUM{ext_rise}})
             & ~{CH_NUM{ext_fall}} & ~hit;
    nxt_ch   = rd.Rd_Channel + CH_W'(1);
  end

  // Pulse counter, saturating trigger counters, armed flags.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      CPT_PULSE <= '0;
      armed     <= '0;
      for (int c = 0; c < CH_NUM; c++) cnt[c] <= '0;
    end else if (start) begin
      CPT_PULSE <= '0;
      armed     <= '0;
      for (int c = 0; c < CH_NUM; c++) cnt[c] <= '0;
    end else begin
      if (counting && ext_rise && CPT_PULSE != '1)
        CPT_PULSE <= CPT_PULSE + CNT_W'(1);
      armed <= arm_nxt;
      for (int c = 0; c < CH_NUM; c++)
        if (hit[c] && cnt[c] != '1)
          cnt[c] <= cnt[c] + CNT_W'(1);
    end
  end

  // Test sequencing and readout handshake.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      Busy          <= 1'b0;
      CPT_DONE      <= 1'b0;
      rd.Rd_Valid   <= 1'b0;
      rd.Rd_Channel <= '0;
      rd.Rd_Data    <= '0;
    end else begin
      unique case (state)
        IDLE: if (Test_Start) begin
          state         <= COUNT;
          Busy          <= 1'b1;
          rd.Rd_Channel <= '0;
          rd.Rd_Data    <= '0;
        end
        COUNT: if (!Test_Start) begin
          state <= IDLE;
          Busy  <= 1'b0;
        end else if (ext_fall && CPT_PULSE >= CPT_MAX) begin
          state <= READOUT;
        end
        READOUT: if (!Test_Start) begin
          state       <= IDLE;
          Busy        <= 1'b0;
          rd.Rd_Valid <= 1'b0;
        end else if (!rd.Rd_Valid) begin
          rd.Rd_Valid <= 1'b1;
          rd.Rd_Data  <= cnt[rd.Rd_Channel];
        end else if (rd.Rd_Ready) begin
          if (rd.Rd_Channel == LAST) begin
            state       <= DONE;
            Busy        <= 1'b0;
            CPT_DONE    <= 1'b1;
            rd.Rd_Valid <= 1'b0;
          end else begin
            rd.Rd_Channel <= nxt_ch;
            rd.Rd_Data    <= cnt[nxt_ch];
          end
        end
        DONE: if (!Test_Start) begin
          state    <= IDLE;
          CPT_DONE <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scurve_multi_channel.sv
// Directed bench for scurve_multi_channel.
// Two instances: default widths and a 4-bit counter build.
module tb_scurve_multi_channel;
  logic        Clk = 1'b0;
  logic        reset_n;
  logic        ts1, ts2, Mode, CLK_EXT;
  logic [3:0]  Trigger, ChannelMask, TriggerDelay;
  logic [15:0] cptmax1, pulse1;
  logic [3:0]  cptmax2, pulse2;
  logic        busy1, busy2, done1, done2;
  logic        rdy, sel;
  logic        cur_valid, cur_done, cur_busy;
  logic [1:0]  cur_ch;
  logic [15:0] cur_data;
  int          n_chk = 0;
  int          n_fail = 0;

  scurve_multi_channel_if #(.CH_W(2), .CNT_W(16)) ia ();
  scurve_multi_channel_if #(.CH_W(2), .CNT_W(4))  ib ();

  assign ia.Rd_Ready = rdy & ~sel;
  assign ib.Rd_Ready = rdy & sel;
  assign cur_valid = sel ? ib.Rd_Valid : ia.Rd_Valid;
  assign cur_ch    = sel ? ib.Rd_Channel : ia.Rd_Channel;
  assign cur_data  = sel ? {12'd0, ib.Rd_Data} : ia.Rd_Data;
  assign cur_done  = sel ? done2 : done1;
  assign cur_busy  = sel ? busy2 : busy1;

  scurve_multi_channel #(.CH_NUM(4), .CNT_W(16), .DLY_W(4)) dut1 (
    .Clk(Clk), .reset_n(reset_n), .Test_Start(ts1), .Mode(Mode),
    .CLK_EXT(CLK_EXT), .Trigger(Trigger), .ChannelMask(ChannelMask),
    .CPT_MAX(cptmax1), .TriggerDelay(TriggerDelay),
    .CPT_PULSE(pulse1), .Busy(busy1), .CPT_DONE(done1), .rd(ia)
  );

  scurve_multi_channel #(.CH_NUM(4), .CNT_W(4), .DLY_W(4)) dut2 (
    .Clk(Clk), .reset_n(reset_n), .Test_Start(ts2), .Mode(Mode),
    .CLK_EXT(CLK_EXT), .Trigger(Trigger), .ChannelMask(ChannelMask),
    .CPT_MAX(cptmax2), .TriggerDelay(TriggerDelay),
    .CPT_PULSE(pulse2), .Busy(busy2), .CPT_DONE(done2), .rd(ib)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic ext_pulse(input logic [3:0] m, input int ntrig,
                           input bit outside);
    CLK_EXT = 1'b1;
    cyc(2);
    for (int k = 0; k < ntrig; k++) begin
      Trigger = ~m; cyc(3);
      Trigger = '1; cyc(3);
    end
    CLK_EXT = 1'b0;
    cyc(4);
    if (outside) begin
      Trigger = ~m; cyc(3);
      Trigger = '1; cyc(4);
    end
  endtask

  task automatic start(input bit s);
    sel = s;
    if (s) ts2 = 1'b1; else ts1 = 1'b1;
    cyc(1);
    chk("start_busy", cur_busy, 1);
  endtask

  task automatic stop();
    ts1 = 1'b0; ts2 = 1'b0;
    cyc(2);
    chk("stop_done", cur_done, 0);
    chk("stop_busy", cur_busy, 0);
  endtask

  task automatic read_all(input string tag, input int e0, input int e1,
                          input int e2, input int e3, input int stall);
    int ev[4];
    int n;
    ev = '{e0, e1, e2, e3};
    rdy = 1'b1;
    for (int ch = 0; ch < 4; ch++) begin
      n = 0;
      while (cur_valid !== 1'b1 && n < 80) begin
        cyc(1); n++;
      end
      chk({tag, "_valid"}, cur_valid, 1);
      chk({tag, "_ch"}, cur_ch, ch);
      chk({tag, "_data"}, cur_data, ev[ch]);
      if (ch == stall) begin
        rdy = 1'b0;
        repeat (3) begin
          cyc(1);
          chk({tag, "_stall_valid"}, cur_valid, 1);
          chk({tag, "_stall_ch"}, cur_ch, ch);
          chk({tag, "_stall_data"}, cur_data, ev[ch]);
        end
        rdy = 1'b1;
      end
      cyc(1);
    end
    rdy = 1'b0;
    chk({tag, "_done"}, cur_done, 1);
    chk({tag, "_valid_low"}, cur_valid, 0);
  endtask

  initial begin
    reset_n = 1'b0; ts1 = 1'b0; ts2 = 1'b0; Mode = 1'b0;
    CLK_EXT = 1'b0; Trigger = '1; ChannelMask = '1;
    cptmax1 = 16'd10; cptmax2 = 4'd10; TriggerDelay = '0;
    rdy = 1'b0; sel = 1'b0;
    cyc(2);
    chk("rst_pulse", pulse1, 0);
    chk("rst_valid", ia.Rd_Valid, 0);
    chk("rst_ch", ia.Rd_Channel, 0);
    chk("rst_data", ia.Rd_Data, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    reset_n = 1'b1;
    cyc(2);

    Mode = 1'b0;
    start(0);
    repeat (10) ext_pulse(4'b0001, 2, 0);
    chk("m0_pulse", pulse1, 10);
    read_all("m0", 20, 0, 0, 0, -1);
    stop();

    Mode = 1'b1;
    start(0);
    repeat (10) ext_pulse(4'b0001, 2, 1);
    chk("m1_pulse", pulse1, 10);
    read_all("m1", 10, 0, 0, 0, -1);
    stop();

    Mode = 1'b0; TriggerDelay = 4'd5; cptmax1 = 16'd2;
    start(0);
    ext_pulse(4'b0001, 1, 0);
    CLK_EXT = 1'b1; cyc(6);
    CLK_EXT = 1'b0; Trigger = 4'b1110; cyc(3);
    Trigger = '1; cyc(4);
    read_all("dly", 2, 0, 0, 0, -1);
    chk("dly_pulse", pulse1, 2);
    stop();
    TriggerDelay = '0;

    ChannelMask = 4'b1101; cptmax1 = 16'd3;
    start(0);
    repeat (3) ext_pulse(4'b1111, 1, 0);
    read_all("mask", 3, 0, 3, 3, 2);
    stop();
    ChannelMask = '1;

    cptmax1 = 16'd10;
    start(0);
    repeat (2) ext_pulse(4'b0001, 1, 0);
    ts1 = 1'b0;
    cyc(1);
    chk("abort_busy", busy1, 0);
    chk("abort_valid", ia.Rd_Valid, 0);
    chk("abort_done", done1, 0);
    chk("abort_pulse", pulse1, 2);
    cyc(10);
    chk("abort_done_late", done1, 0);

    start(1);
    repeat (10) ext_pulse(4'b0001, 2, 0);
    chk("sat_pulse", pulse2, 10);
    read_all("sat", 15, 0, 0, 0, -1);
    stop();
    sel = 1'b0;

    start(0);
    ext_pulse(4'b0001, 1, 0);
    chk("mid_pulse", pulse1, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_pulse", pulse1, 0);
    chk("mid_rst_done", done1, 0);
    ts1 = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    chk("post_rst_busy", busy1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
